bk_cmd_arb: RTL

BK_CMD_ARB -- requirements
Module: bk_cmd_arb

---
 rtl/dram_cmd_pkg.sv | 25 ++
 rtl/bk_cmd_arb_if.sv | 27 ++
 rtl/rr_arb.sv | 27 ++
 rtl/bk_cmd_arb.sv | 116 +++++++++++
 4 files changed

// File: rtl/dram_cmd_pkg.sv
// DRAM command set and the DFI {cs_n, ras_n, cas_n, we_n} encodings shared by the
// command arbiter.
package dram_cmd_pkg;

    typedef enum logic [2:0] {NOP, ACT, RD, WR, PRE, REF} cmd_e;

    localparam logic [3:0] ENC_NOP = 4'b1111;
    localparam logic [3:0] ENC_ACT = 4'b0011;
    localparam logic [3:0] ENC_RD  = 4'b0101;
    localparam logic [3:0] ENC_WR  = 4'b0100;
    localparam logic [3:0] ENC_PRE = 4'b0010;
    localparam logic [3:0] ENC_REF = 4'b0001;

    function automatic logic [3:0] cmd_enc(input cmd_e c);
        case (c)
            ACT:     return ENC_ACT;
            RD:      return ENC_RD;
            WR:      return ENC_WR;
            PRE:     return ENC_PRE;
            REF:     return ENC_REF;
            default: return ENC_NOP;
        endcase
    endfunction

endpackage

// File: rtl/bk_cmd_arb_if.sv
// Bank-scheduler request/grant bundle plus the registered DFI command outputs.
interface bk_cmd_arb_if #(
    parameter int NUM_BANK = 4,
    parameter int RA_W     = 13,
    parameter int CA_W     = 10,
    parameter int ADDR_W   = 14
);
    logic [NUM_BANK-1:0]         act_req, rd_req, wr_req, pre_req, ref_req;
    logic [NUM_BANK*RA_W-1:0]    ra;
    logic [NUM_BANK*CA_W-1:0]    ca;
    logic [NUM_BANK-1:0]         act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic                        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
    logic [$clog2(NUM_BANK)-1:0] dfi_bank;
    logic [ADDR_W-1:0]           dfi_address;

    modport master (
        output act_req, rd_req, wr_req, pre_req, ref_req, ra, ca,
        input  act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
        input  dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address
    );

    modport slave (
        input  act_req, rd_req, wr_req, pre_req, ref_req, ra, ca,
        output act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt,
        output dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_bank, dfi_address
    );
endinterface

// File: rtl/rr_arb.sv
// Round-robin picker: first set request at or after ptr, wrapping; one-hot grant.
// N must be a power of two so the pointer offset wraps by truncation.
module rr_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + PW'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bk_cmd_arb.sv
// Per-cycle DRAM command arbiter: REF > column > PRE > ACT with inter-command
// spacing counters, round-robin bank choice and a registered DFI command stage.
module bk_cmd_arb
    import dram_cmd_pkg::*;
#(
    parameter int NUM_BANK = 4,
    parameter int RA_W     = 13,
    parameter int CA_W     = 10,
    parameter int ADDR_W   = 14,
    parameter int TW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_done,
    input  logic [TW-1:0] t_rrd,
    input  logic [TW-1:0] t_ccd,
    input  logic [TW-1:0] t_wtr,
    input  logic [TW-1:0] t_rtw,
    bk_cmd_arb_if.slave   bus
);
    localparam int BW = $clog2(NUM_BANK);

    logic [BW-1:0]       rr_ptr, win_bank;
    logic [TW-1:0]       cnt_rrd, cnt_ccd, cnt_wtr, cnt_rtw;
    logic [NUM_BANK-1:0] col_req, act_elig, col_oh, pre_oh, act_oh, win_oh;
    logic                rd_ok, wr_ok, act_ok;
    logic [ADDR_W-1:0]   win_addr;
    logic [3:0]          dfi_cmd;
    cmd_e                cmd;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - TW'(1);
    endfunction

    assign rd_ok  = (cnt_ccd == '0) && (cnt_wtr == '0);
    assign wr_ok  = (cnt_ccd == '0) && (cnt_rtw == '0);
    assign act_ok = (cnt_rrd == '0);

    // Timing-blocked requests are masked before arbitration so a blocked class
    // falls through to the next one in the same cycle.
    assign col_req  = (bus.rd_req & {NUM_BANK{rd_ok}}) | (bus.wr_req & {NUM_BANK{wr_ok}});
    assign act_elig = bus.act_req & {NUM_BANK{act_ok}};

    rr_arb #(.N(NUM_BANK)) u_col (.req(col_req),     .ptr(rr_ptr), .gnt(col_oh));
    rr_arb #(.N(NUM_BANK)) u_pre (.req(bus.pre_req), .ptr(rr_ptr), .gnt(pre_oh));
    rr_arb #(.N(NUM_BANK)) u_act (.req(act_elig),    .ptr(rr_ptr), .gnt(act_oh));

    always_comb begin
        cmd    = NOP;
        win_oh = '0;
        if (!rst && init_done) begin
            if (&bus.ref_req) begin
                cmd = REF;
            end else if (|col_oh) begin
                win_oh = col_oh;
                // A bank asking for both RD and WR gets the RD when it is legal.
                cmd = ((|(col_oh & bus.rd_req)) && rd_ok) ? RD : WR;
            end else if (|pre_oh) begin
                win_oh = pre_oh;
                cmd    = PRE;
            end else if (|act_oh) begin
                win_oh = act_oh;
                cmd    = ACT;
            end
        end
    end

    always_comb begin
        win_bank = '0;
        for (int i = 0; i < NUM_BANK; i++)
            if (win_oh[i]) win_bank = BW'(i);
    end

    always_comb begin
        win_addr = '0;
        case (cmd)
            ACT: win_addr = ADDR_W'(bus.ra[int'(win_bank)*RA_W +: RA_W]);
            RD, WR: begin
                win_addr     = ADDR_W'(bus.ca[int'(win_bank)*CA_W +: CA_W]);
                win_addr[10] = 1'b0;
            end
            default: win_addr = '0;
        endcase
    end

    assign bus.act_gnt = (cmd == ACT) ? win_oh : '0;
    assign bus.rd_gnt  = (cmd == RD)  ? win_oh : '0;
    assign bus.wr_gnt  = (cmd == WR)  ? win_oh : '0;
    assign bus.pre_gnt = (cmd == PRE) ? win_oh : '0;
    assign bus.ref_gnt = {NUM_BANK{cmd == REF}};

    assign {bus.dfi_cs_n, bus.dfi_ras_n, bus.dfi_cas_n, bus.dfi_we_n} = dfi_cmd;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_rrd         <= '0;
            cnt_ccd         <= '0;
            cnt_wtr         <= '0;
            cnt_rtw         <= '0;
            rr_ptr          <= '0;
            dfi_cmd         <= ENC_NOP;
            bus.dfi_bank    <= '0;
            bus.dfi_address <= '0;
        end else begin
            cnt_rrd <= (cmd == ACT)              ? sat_dec(t_rrd) : sat_dec(cnt_rrd);
            cnt_ccd <= (cmd == RD || cmd == WR)  ? sat_dec(t_ccd) : sat_dec(cnt_ccd);
            cnt_wtr <= (cmd == WR)               ? sat_dec(t_wtr) : sat_dec(cnt_wtr);
            cnt_rtw <= (cmd == RD)               ? sat_dec(t_rtw) : sat_dec(cnt_rtw);
            if (cmd inside {ACT, RD, WR, PRE})
                rr_ptr <= (win_bank == BW'(NUM_BANK-1)) ? '0 : win_bank + BW'(1);
            dfi_cmd         <= cmd_enc(cmd);
            bus.dfi_bank    <= win_bank;
            bus.dfi_address <= win_addr;
        end
    end
endmodule
